// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage payload types, their halt-bit positions and pipe_latch
// parameter legality checks.
package pipe_pkg;
  localparam int MIN_DEPTH = 1;
  localparam int MAX_DEPTH = 2;
  function automatic bit depth_ok(input int d);
    return d >= MIN_DEPTH && d <= MAX_DEPTH;
  endfunction
  // Every payload keeps its halt flag in the LSB so HALT_BIT is uniform.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halt;
  } fetch_decode_t;
  localparam int FD_HALT_BIT = 0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        halt;
  } decode_exec_t;
  localparam int DE_HALT_BIT = 0;
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        halt;
  } exec_mem_t;
  localparam int EM_HALT_BIT = 0;
  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        halt;
  } mem_wb_t;
  localparam int MW_HALT_BIT = 0;
endpackage

// File: rtl/pipe_latch_sat_counter.sv
// sat_counter: up-counter that sticks at its maximum instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);
  logic [CNT_W-1:0] value_q, value_d;
  assign value_d = (inc && value_q != '1) ? value_q + 1'b1 : value_q;
  assign value = value_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) value_q <= '0;
    else value_q <= value_d;
endmodule

// File: rtl/pipe_latch.sv
// pipe_latch: one- or two-entry elastic pipeline register with flush, sticky
// halt on a halt-marked pop and a saturating downstream-stall counter.
module pipe_latch
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1,
  parameter int HALT_BIT = 0,
  parameter int CNT_W    = 16,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);
  if (!depth_ok(DEPTH) || HALT_BIT >= WIDTH || WIDTH < 1) begin : g_bad_param
    $error("pipe_latch: illegal DEPTH/WIDTH/HALT_BIT");
  end
  logic [WIDTH-1:0] mem_q [2];
  logic [CW-1:0]    count_q, count_d;
  logic             rd_q, rd_d, wr_q, wr_d, halted_q, halted_d;
  logic             push, pop, full;
  assign full      = count_q == CW'(DEPTH);
  assign out_valid = (count_q != '0) & !halted_q;
  assign out_data  = mem_q[rd_q];
  // Only the single-entry latch may look through to out_ready; the skid
  // buffer keeps in_ready purely registered.
  assign in_ready  = !halted_q & (!full | ((DEPTH == 1) & out_ready));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;
  assign halted    = halted_q;
  always_comb begin
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    rd_d     = flush ? 1'b0 : rd_q ^ (pop & (DEPTH == 2));
    wr_d     = flush ? 1'b0 : wr_q ^ (push & (DEPTH == 2));
    halted_d = halted_q | (pop & !flush & out_data[HALT_BIT]);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      count_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      halted_q <= halted_d;
    end
  always_ff @(posedge CLK)
    if (push && !flush) mem_q[wr_q] <= in_data;
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (out_valid & !out_ready),
    .value(stall_cycles)
  );
endmodule

// File: tb/tb_pipe_latch.sv
// tb_pipe_latch: directed checks of a DEPTH=1 latch (a_*) and a DEPTH=2 skid
// buffer (b_*) sharing one clock and reset.
module tb_pipe_latch;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        a_in_valid = 0, a_out_ready = 0, a_flush = 0;
  logic        a_in_ready, a_out_valid, a_halted;
  logic [31:0] a_in_data = '0, a_out_data;
  logic [0:0]  a_count;
  logic [3:0]  a_stall;
  logic        b_in_valid = 0, b_out_ready = 0, b_flush = 0;
  logic        b_in_ready, b_out_valid, b_halted;
  logic [31:0] b_in_data = '0, b_out_data;
  logic [1:0]  b_count;
  logic [15:0] b_stall;
  int n_cmp = 0, n_err = 0;
  always #5 CLK = ~CLK;
  pipe_latch #(.WIDTH(32), .DEPTH(1), .HALT_BIT(31), .CNT_W(4)) u_a (
    .CLK(CLK), .RST(RST), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .flush(a_flush), .count(a_count),
    .halted(a_halted), .stall_cycles(a_stall));
  pipe_latch #(.WIDTH(32), .DEPTH(2), .HALT_BIT(31), .CNT_W(16)) u_b (
    .CLK(CLK), .RST(RST), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .flush(b_flush), .count(b_count),
    .halted(b_halted), .stall_cycles(b_stall));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    step();
    step();
    RST = 1'b0;
    chk("rst a_in_ready", a_in_ready, 1);
    chk("rst a_out_valid", a_out_valid, 0);
    chk("rst a_count", a_count, 0);
    chk("rst a_halted", a_halted, 0);
    chk("rst a_stall", a_stall, 0);
    chk("rst b_in_ready", b_in_ready, 1);
    chk("rst b_count", b_count, 0);
    // streaming through the single-entry latch
    a_out_ready = 1;
    a_in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      a_in_data = i;
      chk("stream in_ready", a_in_ready, 1);
      step();
      chk("stream out_valid", a_out_valid, 1);
      chk("stream out_data", a_out_data, i);
    end
    a_in_valid = 0;
    step();
    chk("stream drained", a_out_valid, 0);
    chk("stream stall", a_stall, 0);
    // skid buffer fills while downstream is blocked
    b_in_valid = 1;
    b_in_data = 32'hA;
    step();
    chk("skid count1", b_count, 1);
    chk("skid ready1", b_in_ready, 1);
    chk("skid head A", b_out_data, 32'hA);
    b_in_data = 32'hB;
    step();
    chk("skid count2", b_count, 2);
    chk("skid ready0", b_in_ready, 0);
    b_in_valid = 0;
    step();
    b_out_ready = 1;
    chk("skid out A", b_out_data, 32'hA);
    step();
    chk("skid out B", b_out_data, 32'hB);
    chk("skid valid B", b_out_valid, 1);
    step();
    chk("skid empty", b_out_valid, 0);
    chk("skid stall", b_stall, 2);
    // flush a full skid buffer while offering 0xC
    b_out_ready = 0;
    b_in_valid = 1;
    b_in_data = 32'h11;
    step();
    b_in_data = 32'h22;
    step();
    chk("flush pre count", b_count, 2);
    b_flush = 1;
    b_out_ready = 1;
    b_in_data = 32'hC;
    step();
    b_flush = 0;
    b_in_valid = 0;
    chk("flush count", b_count, 0);
    chk("flush out_valid", b_out_valid, 0);
    step();
    chk("flush stays empty", b_out_valid, 0);
    // flush on the latch while it actually accepts a push
    a_in_valid = 1;
    a_in_data = 32'hD;
    step();
    chk("aflush pre", a_count, 1);
    a_flush = 1;
    a_in_data = 32'hC;
    chk("aflush push ok", a_in_ready, 1);
    step();
    a_flush = 0;
    a_in_valid = 0;
    chk("aflush count", a_count, 0);
    chk("aflush out_valid", a_out_valid, 0);
    // halt: 0x5, halt word, 0x7 through the skid buffer
    b_out_ready = 1;
    b_in_valid = 1;
    b_in_data = 32'h5;
    step();
    chk("halt out 5", b_out_data, 32'h5);
    b_in_data = 32'h8000_0009;
    step();
    chk("halt out H", b_out_data, 32'h8000_0009);
    chk("halt not yet", b_halted, 0);
    b_in_data = 32'h7;
    step();
    b_in_valid = 0;
    chk("halted set", b_halted, 1);
    chk("halted out_valid", b_out_valid, 0);
    chk("halted in_ready", b_in_ready, 0);
    chk("halted held 7", b_count, 1);
    step();
    step();
    chk("halted still", b_out_valid | b_in_ready, 0);
    // stall counter saturation on the 4-bit latch
    a_out_ready = 0;
    a_in_valid = 1;
    a_in_data = 32'h9;
    step();
    a_in_valid = 0;
    chk("sat full ready0", a_in_ready, 0);
    for (int i = 0; i < 10; i++) step();
    chk("sat stall10", a_stall, 10);
    for (int i = 0; i < 10; i++) step();
    chk("sat stall15", a_stall, 15);
    chk("sat valid held", a_out_valid, 1);
    // asynchronous reset between edges
    #1;
    RST = 1;
    #1;
    chk("arst a_out_valid", a_out_valid, 0);
    chk("arst a_count", a_count, 0);
    chk("arst a_stall", a_stall, 0);
    chk("arst a_in_ready", a_in_ready, 1);
    chk("arst b_halted", b_halted, 0);
    chk("arst b_in_ready", b_in_ready, 1);
    chk("arst b_count", b_count, 0);
    RST = 0;
    a_out_ready = 1;
    a_in_valid = 1;
    a_in_data = 32'h42;
    step();
    a_in_valid = 0;
    chk("post rst push", a_out_data, 32'h42);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
